fetch_unit: RTL

//  Instruction-fetch front end. Holds the fetch PC, drives the synchronous instruction memory and

---
 rtl/hard3_pkg.sv | 25 ++
 rtl/fetch_unit.sv | 135 +++++++++++++
 2 files changed

// File: rtl/hard3_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   ADDR_W / INSTR_W : address and instruction widths
//   addr_t / instr_t : convenience types for those widths
//   state_e          : fetch control state (running or halted)
//   DEF_*            : default reset PC, bubble and halt encodings
package hard3_pkg;

  localparam int ADDR_W  = 12;
  localparam int INSTR_W = 16;
  localparam int COUNT_W = 16;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [INSTR_W-1:0] instr_t;
  typedef logic [COUNT_W-1:0] count_t;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_e;

  localparam addr_t  DEF_RESET_PC   = 12'h000;
  localparam instr_t DEF_NOP_INSTR  = 16'h0000;
  localparam instr_t DEF_HALT_INSTR = 16'hC0F0;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: holds the fetch PC, drives a synchronous
// instruction memory and registers each returned word into the decode (D)
// stage. A taken branch (computed externally from pc/instr) redirects fetch
// and costs exactly one bubble. Fetching stops for good on HALT_INSTR.
//
// Ports
//   clk        in   rising-edge clock for all state
//   rst        in   synchronous active-high reset, overrides everything
//   stall      in   downstream cannot take D this cycle; hold D and F
//   jflag      in   branch taken for the current D instruction
//   jdest      in   branch target for the current D instruction
//   imem_addr  out  memory read address (combinational), sampled at clk edge
//   imem_rdata in   memory data for the address sampled at the previous edge
//   pc         out  address of the D-stage instruction
//   instr      out  D-stage instruction (NOP_INSTR when not valid)
//   valid      out  pc/instr hold a real instruction
//   halted     out  HALT_INSTR accepted; fetch stopped
//   icount     out  accepted D instructions, wraps at 16 bits
module fetch_unit
  import hard3_pkg::*;
#(
  parameter addr_t  RESET_PC   = DEF_RESET_PC,
  parameter instr_t NOP_INSTR  = DEF_NOP_INSTR,
  parameter instr_t HALT_INSTR = DEF_HALT_INSTR
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   stall,
  input  logic   jflag,
  input  addr_t  jdest,
  output addr_t  imem_addr,
  input  instr_t imem_rdata,
  output addr_t  pc,
  output instr_t instr,
  output logic   valid,
  output logic   halted,
  output count_t icount
);

  // fpc_q is the address whose data is currently on imem_rdata.
  state_e state_q,  state_d;
  addr_t  fpc_q,    fpc_d;
  addr_t  pc_q,     pc_d;
  instr_t instr_q,  instr_d;
  logic   valid_q,  valid_d;
  logic   halted_q, halted_d;
  count_t icount_q, icount_d;

  addr_t  fpc_inc;
  logic   accept;
  logic   taken;
  logic   halt_hit;

  // Address arithmetic is modulo 2^ADDR_W; FFF+1 wraps to 000 by truncation.
  assign fpc_inc  = fpc_q + addr_t'(1);
  assign accept   = valid_q & ~stall & (state_q == S_RUN);
  // jflag is only meaningful for a real instruction leaving D this cycle.
  assign taken    = accept & jflag;
  assign halt_hit = accept & (instr_q == HALT_INSTR);

  // Under stall the memory re-reads fpc so the in-flight word is still on
  // imem_rdata when the stall releases.
  always_comb begin
    if (rst)                      imem_addr = RESET_PC;
    else if (state_q == S_HALT)   imem_addr = fpc_q;
    else if (taken)               imem_addr = jdest;
    else if (stall)               imem_addr = fpc_q;
    else                          imem_addr = fpc_inc;
  end

  always_comb begin
    // NOTE: every next-state variable gets a hold default first, so no path
    // through the branches below can infer a latch.
    state_d  = state_q;
    fpc_d    = fpc_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    icount_d = icount_q;

    if (accept) begin
      icount_d = icount_q + count_t'(1);
    end

    if (state_q == S_RUN && !stall) begin
      if (halt_hit) begin
        // Halt wins over a simultaneous branch; fpc/pc freeze from here on.
        state_d  = S_HALT;
        halted_d = 1'b1;
        valid_d  = 1'b0;
        instr_d  = NOP_INSTR;
      end else if (taken) begin
        // Squash the word in flight; the target arrives one edge later.
        valid_d  = 1'b0;
        instr_d  = NOP_INSTR;
        fpc_d    = jdest;
      end else begin
        pc_d     = fpc_q;
        instr_d  = imem_rdata;
        valid_d  = 1'b1;
        fpc_d    = fpc_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q  <= S_RUN;
      fpc_q    <= RESET_PC;
      pc_q     <= RESET_PC;
      instr_q  <= NOP_INSTR;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      icount_q <= '0;
    end else begin
      state_q  <= state_d;
      fpc_q    <= fpc_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      icount_q <= icount_d;
    end
  end

  assign pc     = pc_q;
  assign instr  = instr_q;
  assign valid  = valid_q;
  assign halted = halted_q;
  assign icount = icount_q;

endmodule
